// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-controlled serial pattern detector with a programmable pattern,
// a saturating match counter, a match threshold and an idle timeout.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection. When it is
// undefined, each match clears the window and needs PAT_W fresh bits before the next compare.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 7,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timed_out
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned SH_W   = PAT_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic [CNT_W-1:0]   match_cnt_d;
  logic               busy_d, hit_d, done_d, timed_out_d;

  logic [PAT_W-1:0]   window;
  logic               is_match;
  logic               cmp_en;
  logic [CNT_W:0]     cnt_inc;
  logic [TO_W:0]      to_inc;

  // Candidate window: the history with the incoming bit appended at the LSB
  assign window   = {shreg_q, x};
  assign is_match = (window == pat_q);
  assign cnt_inc  = {1'b0, match_cnt} + (CNT_W + 1)'(1);
  assign to_inc   = {1'b0, to_cnt_q} + (TO_W + 1)'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    fill_cnt_d  = fill_cnt_q;
    to_cnt_d    = to_cnt_q;
    pat_d       = pat_q;
    thresh_d    = thresh_q;
    timeout_d   = timeout_q;
    match_cnt_d = match_cnt;
    timed_out_d = timed_out;
    hit_d       = 1'b0;
    cmp_en      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_FILL;
          shreg_d     = '0;
          fill_cnt_d  = '0;
          to_cnt_d    = '0;
          match_cnt_d = '0;
          timed_out_d = 1'b0;
          pat_d       = cfg_pattern;
          thresh_d    = cfg_thresh;
          timeout_d   = cfg_timeout;
        end
      end
      S_FILL: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (x_valid) begin
          shreg_d = window[SH_W-1:0];
          if (fill_cnt_q == FILL_W'(PAT_W - 1)) begin
            fill_cnt_d = FILL_W'(PAT_W);
            state_d    = S_RUN;
            cmp_en     = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (x_valid) begin
          shreg_d = window[SH_W-1:0];
          cmp_en  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Compare a full window; the fill-completing bit never advances the idle timer
    if (cmp_en) begin
      if (is_match) begin
        hit_d    = 1'b1;
        to_cnt_d = '0;
        if (match_cnt != {CNT_W{1'b1}}) begin
          match_cnt_d = cnt_inc[CNT_W-1:0];
        end
        if ((thresh_q != '0) && (cnt_inc == {1'b0, thresh_q})) begin
          state_d = S_DONE;
        end else begin
`ifdef SEQ_DET_OVERLAP_EN
          state_d = S_RUN;
`else
          shreg_d    = '0;
          fill_cnt_d = '0;
          state_d    = S_FILL;
`endif
        end
      end else if (state_q == S_RUN) begin
        if ((timeout_q != '0) && (to_inc == {1'b0, timeout_q})) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else begin
          to_cnt_d = to_inc[TO_W-1:0];
        end
      end
    end

    busy_d = (state_d == S_FILL) || (state_d == S_RUN);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      fill_cnt_q <= '0;
      to_cnt_q   <= '0;
      pat_q      <= '0;
      thresh_q   <= '0;
      timeout_q  <= '0;
      match_cnt  <= '0;
      busy       <= 1'b0;
      hit        <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fill_cnt_q <= fill_cnt_d;
      to_cnt_q   <= to_cnt_d;
      pat_q      <= pat_d;
      thresh_q   <= thresh_d;
      timeout_q  <= timeout_d;
      match_cnt  <= match_cnt_d;
      busy       <= busy_d;
      hit        <= hit_d;
      done       <= done_d;
      timed_out  <= timed_out_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a reference model predicts each cycle's outputs into a queue,
// a monitor pops and compares them one cycle later. Honours SEQ_DET_OVERLAP_EN.
module tb_seq_det_ctrl;

  localparam int unsigned PAT_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, stop = 1'b0, x = 1'b0, x_valid = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             busy, hit, done, timed_out;
  logic [CNT_W-1:0] match_cnt;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh), .cfg_timeout(cfg_timeout),
    .x(x), .x_valid(x_valid), .busy(busy), .hit(hit), .match_cnt(match_cnt),
    .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             hit;
    logic             done;
    logic             timed_out;
    logic [CNT_W-1:0] mcnt;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0, n_err = 0;
  int   dut_hits = 0, dut_dones = 0;

  // configuration applied together with the next driven cycle
  logic [PAT_W-1:0] n_pat = '0;
  logic [CNT_W-1:0] n_thr = '0;
  logic [TO_W-1:0]  n_tout = '0;

  // reference model: 0 idle, 1 active (filling or running), 2 done
  int   m_mode = 0, m_n = 0, m_cnt = 0, m_gap = 0, m_thr = 0, m_tout = 0, m_pat = 0;
  bit   m_to = 1'b0;
  bit   m_win[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Predict the outputs after the coming clock edge from the current inputs
  task automatic model();
    exp_t e;
    int   v;
    bit   reached;
    e = '0;
    if (!rst) begin
      m_mode = 0; m_n = 0; m_cnt = 0; m_gap = 0; m_to = 1'b0;
      m_pat = 0; m_thr = 0; m_tout = 0;
      m_win.delete();
      expq.push_back(e);
      return;
    end
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_n = 0; m_cnt = 0; m_gap = 0; m_to = 1'b0;
        m_win.delete();
        m_pat = int'(cfg_pattern); m_thr = int'(cfg_thresh); m_tout = int'(cfg_timeout);
      end
    end else if (stop) begin
      m_mode = 2; e.done = 1'b1;
    end else if (x_valid) begin
      m_win.push_back(x);
      if (m_win.size() > PAT_W) void'(m_win.pop_front());
      m_n++;
      if (m_n >= PAT_W) begin
        v = 0;
        foreach (m_win[i]) v = v * 2 + int'(m_win[i]);
        if (v == m_pat) begin
          e.hit = 1'b1;
          reached = (m_thr != 0) && (m_cnt + 1 == m_thr);
          if (m_cnt < 255) m_cnt++;
          m_gap = 0;
          if (reached) begin
            m_mode = 2; e.done = 1'b1;
          end else if (!OVL) begin
            m_win.delete(); m_n = 0;
          end
        end else if (m_n > PAT_W) begin
          m_gap++;
          if (m_tout != 0 && m_gap == m_tout) begin
            m_mode = 2; e.done = 1'b1; m_to = 1'b1;
          end
        end
      end
    end
    e.busy = (m_mode == 1);
    e.timed_out = m_to;
    e.mcnt = CNT_W'(m_cnt);
    expq.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and predict its result
  task automatic cyc(input logic r, input logic st, input logic sp, input logic xv, input logic xb);
    @(negedge clk);
    rst = r; start = st; stop = sp; x_valid = xv; x = xb;
    cfg_pattern = n_pat; cfg_thresh = n_thr; cfg_timeout = n_tout;
    model();
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b0, 1'b0, 1'b1, b[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the predictions
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (hit === 1'b1) dut_hits++;
      if (done === 1'b1) dut_dones++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("hit", 32'(hit), 32'(e.hit));
        chk("done", 32'(done), 32'(e.done));
        chk("timed_out", 32'(timed_out), 32'(e.timed_out));
        chk("match_cnt", 32'(match_cnt), 32'(e.mcnt));
      end
    end
  end

  initial begin
    int   h0, d0;
    logic st, sp, xv, xb, r;
    bit   pend[$];
    logic [PAT_W-1:0] p;

    // 1: reset held with random activity
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    idle(1);

    // 2: two back-to-back patterns sharing a bit
    n_pat = 7'b1111001; n_thr = '0; n_tout = '0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    h0 = dut_hits;
    send(32'b1111001111001, 13);
    idle(2);
    chk("t2_hits", 32'(dut_hits - h0), OVL ? 32'd2 : 32'd1);
    chk("t2_cnt", 32'(match_cnt), OVL ? 32'd2 : 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // 3: threshold of two ends the run on the second match
    n_thr = 8'd2;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    h0 = dut_hits; d0 = dut_dones;
    for (int k = 0; k < 3; k++) send(32'b1111001, 7);
    idle(2);
    chk("t3_hits", 32'(dut_hits - h0), 32'd2);
    chk("t3_dones", 32'(dut_dones - d0), 32'd1);
    chk("t3_cnt", 32'(match_cnt), 32'd2);
    chk("t3_busy", 32'(busy), 32'd0);

    // 4: timeout of five no-match bits, long invalid gaps do not count
    n_thr = '0; n_tout = 16'd5;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    d0 = dut_dones;
    send(32'b0000000, 7);
    idle(20);
    send(32'b00, 2);
    idle(20);
    chk("t4_no_early_to", 32'(timed_out), 32'd0);
    send(32'b000, 3);
    idle(2);
    chk("t4_to", 32'(timed_out), 32'd1);
    chk("t4_dones", 32'(dut_dones - d0), 32'd1);

    // 5: stop on the completing bit, start while busy ignored
    n_tout = '0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    h0 = dut_hits; d0 = dut_dones;
    send(32'b111, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b100, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("t5_hits", 32'(dut_hits - h0), 32'd0);
    chk("t5_cnt", 32'(match_cnt), 32'd0);
    chk("t5_dones", 32'(dut_dones - d0), 32'd1);

    // 6: reset mid-run after three matches, then restart
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send(32'b1111001, 7);
    idle(1);
    chk("t6_cnt_pre", 32'(match_cnt), 32'd3);
    d0 = dut_dones;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6_cnt_rst", 32'(match_cnt), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t6_no_done", 32'(dut_dones - d0), 32'd0);
    chk("t6_restart", 32'(busy), 32'd1);

    // Random traffic with injected patterns, random config, stops and resets
    for (int c = 0; c < 4000; c++) begin
      st = 1'b0;
      if (m_mode != 1 && $urandom_range(3) == 0) begin
        st = 1'b1;
        n_pat  = ($urandom_range(1) == 0) ? 7'b1111001 : PAT_W'($urandom);
        n_thr  = CNT_W'($urandom_range(4));
        n_tout = TO_W'($urandom_range(12));
      end
      if (pend.size() == 0) begin
        if ($urandom_range(1) == 0) begin
          p = n_pat;
          for (int i = PAT_W - 1; i >= 0; i--) pend.push_back(p[i]);
        end else begin
          for (int i = 0; i < int'($urandom_range(8, 1)); i++) pend.push_back(1'($urandom));
        end
      end
      xv = ($urandom_range(3) != 0);
      xb = 1'($urandom);
      if (xv) xb = pend.pop_front();
      sp = ($urandom_range(150) == 0);
      r  = ($urandom_range(900) != 0);
      cyc(r, st, sp, xv, xb);
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
